ibex_instr_ahbl_bridge: RTL and testbench

- Converts the Ibex core instruction-fetch interface (req/gnt/rvalid) into a single-master AHB-Lite read-only master port.
- Sits directly upstream of the instruction SRAM AHB-Lite slave and drives its address/control inputs.
- Consumes the slave's hrdata/hready/hresp.
- Supports AHB pipelining: one address phase may overlap one data phase. This gives back-to-back single-cycle fetches when hready is held high.

---
 rtl/system_pkg.sv | 20 ++
 rtl/ibex_instr_ahbl_bridge.sv | 167 ++++++++++++++++
 tb/tb_ibex_instr_ahbl_bridge.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/system_pkg.sv
// Shared AHB-Lite encodings, bus widths and the fetch FSM state type
// used by the Ibex instruction-fetch bridge.
package system_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE       = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ     = 2'b10;
  localparam logic [2:0] HSIZE_WORD        = 3'b010;
  localparam logic [2:0] HBURST_SINGLE     = 3'b000;
  localparam logic [3:0] HPROT_OPCODE_PRIV = 4'b0010;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_ERR  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/ibex_instr_ahbl_bridge.sv
// Ibex instruction-fetch (req/gnt/rvalid) to AHB-Lite read-only master, one address phase overlapping one data phase.
// Optional FETCH_ADDR_CHECK_EN: out-of-region fetches are answered locally with an error instead of reaching the bus.
module ibex_instr_ahbl_bridge #(
  parameter int unsigned                           ADDR_WIDTH = system_pkg::ADDR_WIDTH,
  parameter int unsigned                           DATA_WIDTH = system_pkg::DATA_WIDTH,
  parameter logic [system_pkg::ADDR_WIDTH-1:0]     ISRAM_BASE = 32'h0000_0000,
  parameter int unsigned                           ISRAM_SIZE = 32'd512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  output logic [ADDR_WIDTH-1:0] ahbl_haddr,
  output logic [2:0]            ahbl_hburst,
  output logic                  ahbl_hmastlock,
  output logic [3:0]            ahbl_hprot,
  output logic [2:0]            ahbl_hsize,
  output logic [1:0]            ahbl_htrans,
  output logic [DATA_WIDTH-1:0] ahbl_hwdata,
  output logic                  ahbl_hwrite,
  input  logic [DATA_WIDTH-1:0] ahbl_hrdata,
  input  logic                  ahbl_hready,
  input  logic                  ahbl_hresp
);

  import system_pkg::*;

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic         bus_ok_s;
  logic         addr_en_s;
  logic         issue_ok_s;
  logic         oor_s;
  logic         local_err_s;

  // The region must be a power of two and the base aligned to it.
  if ((ISRAM_SIZE == 32'd0) || ((ISRAM_SIZE & (ISRAM_SIZE - 32'd1)) != 32'd0) ||
      ((ISRAM_BASE & ADDR_WIDTH'(ISRAM_SIZE - 32'd1)) != '0)) begin : g_bad_region
    $error("ISRAM_SIZE must be a non-zero power of two with ISRAM_BASE aligned to it");
  end

`ifdef FETCH_ADDR_CHECK_EN
  logic                  local_err_r;
  logic [ADDR_WIDTH-1:0] addr_off_s;

  assign addr_off_s  = instr_addr_i - ISRAM_BASE;
  assign oor_s       = (addr_off_s >= ADDR_WIDTH'(ISRAM_SIZE));
  assign local_err_s = local_err_r;

  // Remembers that the pending data phase is a locally generated error.
  always_ff @(posedge clk) begin
    if (rst) begin
      local_err_r <= 1'b0;
    end else begin
      local_err_r <= instr_gnt_o & oor_s;
    end
  end
`else
  logic unused_addr_lsb;

  assign oor_s           = 1'b0;
  assign local_err_s     = 1'b0;
  assign unused_addr_lsb = ^instr_addr_i[1:0];
`endif

  assign ahbl_hburst    = HBURST_SINGLE;
  assign ahbl_hmastlock = 1'b0;
  assign ahbl_hprot     = HPROT_OPCODE_PRIV;
  assign ahbl_hsize     = HSIZE_WORD;
  assign ahbl_hwdata    = '0;
  assign ahbl_hwrite    = 1'b0;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        state_nxt_s = instr_gnt_o ? S_DATA : S_IDLE;
      end
      S_DATA: begin
        if (local_err_s) begin
          state_nxt_s = instr_gnt_o ? S_DATA : S_IDLE;
        end else if (ahbl_hresp) begin
          // hresp with hready in the first cycle is a protocol violation; close it out as an error.
          state_nxt_s = ahbl_hready ? S_IDLE : S_ERR;
        end else if (ahbl_hready) begin
          state_nxt_s = instr_gnt_o ? S_DATA : S_IDLE;
        end else begin
          state_nxt_s = S_DATA;
        end
      end
      S_ERR: begin
        state_nxt_s = ahbl_hready ? S_IDLE : S_ERR;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM outputs: address phase towards the bus, response towards the core.
  always_comb begin
    bus_ok_s       = ahbl_hready & ~ahbl_hresp;
    addr_en_s      = 1'b0;
    issue_ok_s     = 1'b0;
    instr_gnt_o    = 1'b0;
    instr_rvalid_o = 1'b0;
    instr_err_o    = 1'b0;
    instr_rdata_o  = '0;
    ahbl_htrans    = HTRANS_IDLE;
    ahbl_haddr     = '0;
    case (state_r)
      S_IDLE: begin
        addr_en_s  = 1'b1;
        issue_ok_s = 1'b1;
      end
      S_DATA: begin
        addr_en_s  = local_err_s | ~ahbl_hresp;
        issue_ok_s = local_err_s | bus_ok_s;
      end
      S_ERR: begin
        addr_en_s  = 1'b0;
        issue_ok_s = 1'b0;
      end
      default: begin
        addr_en_s  = 1'b0;
        issue_ok_s = 1'b0;
      end
    endcase
    if (rst) begin
      ahbl_htrans = HTRANS_IDLE;
    end else begin
      instr_gnt_o = instr_req_i & issue_ok_s & (oor_s | ahbl_hready);
      ahbl_htrans = (instr_req_i & addr_en_s & ~oor_s) ? HTRANS_NONSEQ : HTRANS_IDLE;
      ahbl_haddr  = {instr_addr_i[ADDR_WIDTH-1:2], 2'b00};
      case (state_r)
        S_DATA: begin
          instr_rvalid_o = local_err_s | ahbl_hready;
          instr_err_o    = instr_rvalid_o & (local_err_s | ahbl_hresp);
        end
        S_ERR: begin
          instr_rvalid_o = ahbl_hready;
          instr_err_o    = ahbl_hready;
        end
        default: begin
          instr_rvalid_o = 1'b0;
          instr_err_o    = 1'b0;
        end
      endcase
      instr_rdata_o = (instr_rvalid_o & ~instr_err_o) ? ahbl_hrdata : '0;
    end
  end

endmodule

// File: tb/tb_ibex_instr_ahbl_bridge.sv
// Scoreboard bench for ibex_instr_ahbl_bridge: a driver issues directed per-cycle vectors and queues
// expected responses at grant time; a monitor pops and compares on every rvalid.
module tb_ibex_instr_ahbl_bridge;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic [31:0] ahbl_haddr;
  logic [2:0]  ahbl_hburst;
  logic        ahbl_hmastlock;
  logic [3:0]  ahbl_hprot;
  logic [2:0]  ahbl_hsize;
  logic [1:0]  ahbl_htrans;
  logic [31:0] ahbl_hwdata;
  logic        ahbl_hwrite;
  logic [31:0] ahbl_hrdata;
  logic        ahbl_hready;
  logic        ahbl_hresp;
  logic [31:0] dp_addr;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ibex_instr_ahbl_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .ahbl_haddr     (ahbl_haddr),
    .ahbl_hburst    (ahbl_hburst),
    .ahbl_hmastlock (ahbl_hmastlock),
    .ahbl_hprot     (ahbl_hprot),
    .ahbl_hsize     (ahbl_hsize),
    .ahbl_htrans    (ahbl_htrans),
    .ahbl_hwdata    (ahbl_hwdata),
    .ahbl_hwrite    (ahbl_hwrite),
    .ahbl_hrdata    (ahbl_hrdata),
    .ahbl_hready    (ahbl_hready),
    .ahbl_hresp     (ahbl_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: word at byte address A reads as 0x1000_0000 | A[31:2].
  always @(posedge clk) begin
    if (ahbl_htrans == 2'b10 && ahbl_hready) dp_addr <= ahbl_haddr;
  end
  assign ahbl_hrdata = 32'h1000_0000 | {2'b00, dp_addr[31:2]};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (instr_rvalid_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid got data=%h err=%b expected no response", instr_rdata_o, instr_err_o);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        if (instr_rdata_o !== e.data || instr_err_o !== e.err) begin
          errors++;
          $display("FAIL response got data=%h err=%b expected data=%h err=%b",
                   instr_rdata_o, instr_err_o, e.data, e.err);
        end
      end
    end
  end

  // One cycle: drive inputs, check handshake at negedge, queue the expected response on grant.
  task automatic step(input logic r, input logic [31:0] a, input logic rdy, input logic rsp,
                      input logic e_gnt, input logic e_ns, input logic e_rv,
                      input logic push, input logic e_err, input logic [31:0] e_data);
    rsp_t item;
    rst = 1'b0; instr_req_i = r; instr_addr_i = a; ahbl_hready = rdy; ahbl_hresp = rsp;
    @(negedge clk);
    chk("gnt", {31'd0, instr_gnt_o}, {31'd0, e_gnt});
    chk("htrans", {30'd0, ahbl_htrans}, e_ns ? 32'h2 : 32'h0);
    chk("rvalid", {31'd0, instr_rvalid_o}, {31'd0, e_rv});
    if (e_ns) chk("haddr", ahbl_haddr, {a[31:2], 2'b00});
    if (push) begin
      item.err = e_err; item.data = e_data;
      sb.push_back(item);
    end
    @(posedge clk); #1;
  endtask

  task automatic rst_check();
    rst = 1'b1; instr_req_i = 1'b1; instr_addr_i = 32'h0000_000C; ahbl_hready = 1'b1; ahbl_hresp = 1'b0;
    @(negedge clk);
    chk("rst_gnt", {31'd0, instr_gnt_o}, 32'd0);
    chk("rst_rvalid", {31'd0, instr_rvalid_o}, 32'd0);
    chk("rst_err", {31'd0, instr_err_o}, 32'd0);
    chk("rst_htrans", {30'd0, ahbl_htrans}, 32'd0);
    chk("rst_haddr", ahbl_haddr, 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; instr_req_i = 1'b0; instr_addr_i = 32'd0;
    ahbl_hready = 1'b1; ahbl_hresp = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_check();
    chk("hburst", {29'd0, ahbl_hburst}, 32'h0);
    chk("hsize", {29'd0, ahbl_hsize}, 32'h2);
    chk("hprot", {28'd0, ahbl_hprot}, 32'h2);
    chk("hwrite_lock", {30'd0, ahbl_hwrite, ahbl_hmastlock}, 32'h0);
    chk("hwdata", ahbl_hwdata, 32'h0);

    // single fetch (low address bits ignored)
    step(1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0001);
    step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // back-to-back
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0000);
    step(1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0001);
    step(1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0002);
    step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // two wait states on 0x10, next request 0x14 held until completion
    step(1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0004);
    step(1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0000_0014, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0000_0014, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_0005);
    step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // two-cycle error response, then a fresh grant
    step(1'b1, 32'h0000_0020, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b1, 32'h0000_0024, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0000_0024, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0000_0024, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_0009);
    step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // hresp with hready in the first cycle: single error response
    step(1'b1, 32'h0000_0028, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h0000_002C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1000_000B);
    step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // reset during the data phase of 0x8: no response for it
    step(1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_check();
    step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

`ifdef FETCH_ADDR_CHECK_EN
    // out-of-region fetch granted locally without hready, then an in-range fetch
    step(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b1, 32'h0000_01FC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1000_007F);
    step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
`endif

    step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
